hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline CPU.
- Keeps a shadow copy of destination/write-enable/load info for the EX, MEM and WB stages. From that it generates PC/IF-ID stall, IF/ID flush, ID/EX bubble and registered forwarding selects.
- Sits beside the ID stage, taking the decoder's per-instruction control fields. Also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cnt / flush_cnt performance counters.
- ZERO_REG, 0, register index that is never hazard-tracked (hardwired zero).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dst  in  5  resolved write register (rt, rd or 31 per s_num_write).
- id_reg_write  in  1  decoder reg_write.
- id_is_load  in  1  decoder s_data_write==2'b01 with reg_write=1 (lw).
- id_npcop  in  3  decoder Npcop: 0 seq, 1 beq, 2 j, 3 jr, 4 jal.
- ex_branch_taken  in  1  beq in EX resolved taken this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- if_id_flush  out  1  replace IF/ID with nop at next edge (combinational).
- id_ex_bubble  out  1  load nop into ID/EX at next edge (combinational).
- fwd_a  out  2  operand A select for the instruction now in EX (registered): 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
- fwd_b  out  2  same for operand B.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- flush_cnt  out  CNT_W  cycles with if_id_flush=1, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - All shadow regs cleared: ex/mem/wb rw=0, dst=0, load=0.
  - fwd_a and fwd_b are 00; both counters are 0.
  - stall, if_id_flush and id_ex_bubble are forced 0 while rst_n=0.
- Hazard qualifiers: a source matches a stage when valid use && src!=ZERO_REG && stage_rw && stage_dst==src.
- load_use = id_valid && ex_load && (rs matches EX || rt matches EX).
- jr_hazard = id_valid && id_npcop==3 && (rs matches EX || rs matches MEM).
  - jr reads the regfile in ID with no ID forwarding.
  - The regfile bypasses same-cycle WB writes internally, so WB is never a hazard.
- Priority, highest first:
  - ex_branch_taken → if_id_flush=1, id_ex_bubble=1, stall=0. This overrides load_use and jr_hazard, since the ID instruction is on the wrong path.
  - load_use || jr_hazard → stall=1, id_ex_bubble=1, if_id_flush=0.
  - id_valid && id_npcop∈{2,3,4} → if_id_flush=1 (one delay-free slot killed), no bubble.
  - Otherwise all three are 0.
- Shadow advance every clk edge:
  - EX ← bubble ? {rw=0,load=0,dst=0} : {id_reg_write&&id_valid, id_is_load&&id_valid, id_dst}.
  - MEM ← EX; WB ← MEM.
- Forwarding, registered at the same edge; only ID sources with use bit set count:
  - fwd_a ← (rs matches EX && !ex_load) ? 01 : (rs matches MEM) ? 10 : 00.
  - fwd_b is the same on rt.
  - EX wins over MEM on double match (youngest producer).
  - When bubble=1, fwd_a and fwd_b are forced 00.
- Latency:
  - Load-use stall lasts exactly 1 cycle; the following cycle the load is in MEM and selects 10.
  - jr stall lasts 1 or 2 cycles until the producer leaves MEM.
- Counters increment at the edge following a cycle with the respective signal high, and saturate at all-ones (no wrap).
- Async reset mid-stall clears state immediately; the first cycle after release has stall=0 unless the inputs recreate a hazard, which cannot happen because shadow rw=0.

Test Plan:
- `lw $2,0($1)` then `add $3,$2,$4` → stall=1, id_ex_bubble=1 for exactly 1 cycle; the cycle add is in EX, fwd_a=10, fwd_b=00; stall_cnt=1.
- `add $2,$1,$1`; `sub $3,$2,$2` → no stall; in sub's EX cycle, fwd_a=01 and fwd_b=01.
- `addi $0,$1,5`; `add $3,$0,$0` → fwd_a=fwd_b=00, stall=0 (zero register is never tracked).
- `add $31,...` immediately followed by `jr $31` → stall for 2 cycles (producer in EX, then MEM), then if_id_flush=1 for 1 cycle; flush_cnt=1.
- beq taken in EX while ID holds a load-use consumer → if_id_flush=1, id_ex_bubble=1, stall=0; next-cycle EX shadow has rw=0.
- Force flush_cnt to all-ones via CNT_W=2 and issue 5 `j` instructions → flush_cnt holds at 3. Pulse rst_n low mid-stall → stall drops to 0 asynchronously; all outputs are 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks producers in EX/MEM,
// stalls for load-use and jr dependencies, flushes on redirects, and counts stall/flush cycles.
module hazard_ctrl #(
    parameter int          CNT_W    = 32,
    parameter logic [4:0]  ZERO_REG = 5'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic [2:0]       id_npcop,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0]       NPC_J   = 3'd2;
    localparam logic [2:0]       NPC_JR  = 3'd3;
    localparam logic [2:0]       NPC_JAL = 3'd4;
    localparam logic [1:0]       FWD_RF  = 2'b00;
    localparam logic [1:0]       FWD_EX  = 2'b01;
    localparam logic [1:0]       FWD_MEM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // WB needs no shadow: the regfile bypasses same-cycle writes, so it never causes a hazard.
    logic       ex_rw;
    logic       ex_load;
    logic [4:0] ex_dst;
    logic       mem_rw;
    logic [4:0] mem_dst;

    logic rs_live;
    logic rt_live;
    logic rs_ex;
    logic rt_ex;
    logic rs_mem;
    logic rt_mem;
    logic load_use;
    logic jr_hazard;
    logic is_jump;

    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    always_comb begin
        rs_live   = id_valid && id_uses_rs && (id_rs != ZERO_REG);
        rt_live   = id_valid && id_uses_rt && (id_rt != ZERO_REG);
        rs_ex     = rs_live && ex_rw  && (ex_dst  == id_rs);
        rt_ex     = rt_live && ex_rw  && (ex_dst  == id_rt);
        rs_mem    = rs_live && mem_rw && (mem_dst == id_rs);
        rt_mem    = rt_live && mem_rw && (mem_dst == id_rt);
        load_use  = id_valid && ex_load && (rs_ex || rt_ex);
        jr_hazard = id_valid && (id_npcop == NPC_JR) && (rs_ex || rs_mem);
        is_jump   = id_valid && ((id_npcop == NPC_J) || (id_npcop == NPC_JR) ||
                                 (id_npcop == NPC_JAL));
    end

    // A taken branch wins: the instruction in ID is on the wrong path, so its hazards are moot.
    always_comb begin
        stall        = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst_n) begin
            stall        = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || jr_hazard) begin
            stall        = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (is_jump) begin
            if_id_flush  = 1'b1;
        end
    end

    // A load still in EX cannot forward; the stall above delays the consumer until MEM.
    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (!id_ex_bubble) begin
            if (rs_ex && !ex_load) fwd_a_nxt = FWD_EX;
            else if (rs_mem)       fwd_a_nxt = FWD_MEM;
            if (rt_ex && !ex_load) fwd_b_nxt = FWD_EX;
            else if (rt_mem)       fwd_b_nxt = FWD_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rw   <= 1'b0;
            ex_load <= 1'b0;
            ex_dst  <= 5'd0;
            mem_rw  <= 1'b0;
            mem_dst <= 5'd0;
            fwd_a   <= FWD_RF;
            fwd_b   <= FWD_RF;
        end else begin
            if (id_ex_bubble) begin
                ex_rw   <= 1'b0;
                ex_load <= 1'b0;
                ex_dst  <= 5'd0;
            end else begin
                ex_rw   <= id_reg_write && id_valid;
                ex_load <= id_is_load && id_valid;
                ex_dst  <= id_dst;
            end
            mem_rw  <= ex_rw;
            mem_dst <= ex_dst;
            fwd_a   <= fwd_a_nxt;
            fwd_b   <= fwd_b_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic checked against
// a history-based model of the in-flight producers.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
    logic [2:0] id_npcop;
    logic       ex_branch_taken;

    logic        stall, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic        stall_s, if_id_flush_s, id_ex_bubble_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_npcop(id_npcop),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_npcop(id_npcop),
        .ex_branch_taken(ex_branch_taken), .stall(stall_s), .if_id_flush(if_id_flush_s),
        .id_ex_bubble(id_ex_bubble_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    // Model: the last two issued instructions (index 0 = now in EX, 1 = now in MEM).
    typedef struct { bit rw; bit ld; int dst; } slot_t;
    slot_t  pipe[2];
    int     m_fwd_a, m_fwd_b;
    longint m_scnt, m_fcnt, m_scnt_s, m_fcnt_s;
    bit     e_stall, e_flush, e_bubble;
    bit     o_stall, o_flush, o_bubble, o_stall_s, o_flush_s, o_bubble_s;

    function automatic bit hit(bit v, int src, bit use_, slot_t s);
        return v && use_ && src != 0 && s.rw && s.dst == src;
    endfunction

    function automatic longint sat_inc(longint c, longint maxv);
        return (c < maxv) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        pipe[0] = '{0, 0, 0};
        pipe[1] = '{0, 0, 0};
        m_fwd_a = 0; m_fwd_b = 0;
        m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dst, input bit rw, input bit ld, input int npc, input bit br);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_dst = 5'(dst); id_reg_write = rw; id_is_load = ld; id_npcop = 3'(npc);
        ex_branch_taken = br;
    endtask

    // Drives one ID cycle, samples the combinational outputs mid-cycle, then advances the model
    // across the edge. Returns #1 after the edge so registered outputs can be compared.
    task automatic apply(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dst, input bit rw, input bit ld, input int npc, input bit br);
        bit rs0, rt0, rs1, lu, jh;
        slot_t nx;
        drive(v, rs, rt, urs, urt, dst, rw, ld, npc, br);
        @(negedge clk);
        rs0 = hit(v, rs, urs, pipe[0]);
        rt0 = hit(v, rt, urt, pipe[0]);
        rs1 = hit(v, rs, urs, pipe[1]);
        lu  = v && pipe[0].ld && (rs0 || rt0);
        jh  = v && npc == 3 && (rs0 || rs1);
        e_stall = 0; e_flush = 0; e_bubble = 0;
        if (br) begin e_flush = 1; e_bubble = 1; end
        else if (lu || jh) begin e_stall = 1; e_bubble = 1; end
        else if (v && npc >= 2 && npc <= 4) e_flush = 1;
        o_stall = stall; o_flush = if_id_flush; o_bubble = id_ex_bubble;
        o_stall_s = stall_s; o_flush_s = if_id_flush_s; o_bubble_s = id_ex_bubble_s;
        if (e_bubble) begin
            nx = '{0, 0, 0};
            m_fwd_a = 0; m_fwd_b = 0;
        end else begin
            nx = '{rw && v, ld && v, dst};
            m_fwd_a = (rs0 && !pipe[0].ld) ? 1 : hit(v, rs, urs, pipe[1]) ? 2 : 0;
            m_fwd_b = (rt0 && !pipe[0].ld) ? 1 : hit(v, rt, urt, pipe[1]) ? 2 : 0;
        end
        if (e_stall) begin
            m_scnt = sat_inc(m_scnt, 64'hFFFF_FFFF); m_scnt_s = sat_inc(m_scnt_s, 3);
        end
        if (e_flush) begin
            m_fcnt = sat_inc(m_fcnt, 64'hFFFF_FFFF); m_fcnt_s = sat_inc(m_fcnt_s, 3);
        end
        @(posedge clk);
        #1;
        pipe[1] = pipe[0];
        pipe[0] = nx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 2, 1);
        #1;
        checks++;
        if ({stall, if_id_flush, id_ex_bubble} !== 3'b000) begin
            errors++; $display("FAIL reset_comb: got %b want 000", {stall, if_id_flush, id_ex_bubble});
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000 || stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_regs: fwd %b%b cnts %0d/%0d want 0", fwd_a, fwd_b, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        apply(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);          // lw $2,0($1)
        apply(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);          // add $3,$2,$4
        checks++;
        if (o_stall !== 1'b1 || o_bubble !== 1'b1 || o_flush !== 1'b0) begin
            errors++; $display("FAIL lu_stall: got s%b b%b f%b want s1 b1 f0", o_stall, o_bubble, o_flush);
        end
        apply(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);          // add held one cycle, now issues
        checks++;
        if (o_stall !== 1'b0) begin
            errors++; $display("FAIL lu_release: stall %b want 0", o_stall);
        end
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00 || stall_cnt !== 32'd1) begin
            errors++; $display("FAIL lu_fwd: fwd %b/%b cnt %0d want 10/00 cnt 1", fwd_a, fwd_b, stall_cnt);
        end
    endtask

    task automatic test_ex_forward();
        do_reset();
        apply(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);          // add $2,$1,$1
        apply(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);          // sub $3,$2,$2
        checks++;
        if (o_stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL ex_fwd: stall %b fwd %b/%b want 0 01/01", o_stall, fwd_a, fwd_b);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        apply(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);          // addi $0,$1,5
        apply(1, 0, 0, 1, 1, 3, 1, 0, 0, 0);          // add $3,$0,$0
        checks++;
        if (o_stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL zero_reg: stall %b fwd %b/%b want 0 00/00", o_stall, fwd_a, fwd_b);
        end
    endtask

    task automatic test_jr();
        do_reset();
        apply(1, 1, 2, 1, 1, 31, 1, 0, 0, 0);         // add $31,$1,$2
        for (int i = 0; i < 2; i++) begin
            apply(1, 31, 0, 1, 0, 0, 0, 0, 3, 0);     // jr $31 waiting
            checks++;
            if (o_stall !== 1'b1 || o_flush !== 1'b0) begin
                errors++; $display("FAIL jr_stall%0d: s%b f%b want s1 f0", i, o_stall, o_flush);
            end
        end
        apply(1, 31, 0, 1, 0, 0, 0, 0, 3, 0);
        checks++;
        if (o_stall !== 1'b0 || o_flush !== 1'b1 || o_bubble !== 1'b0) begin
            errors++; $display("FAIL jr_go: s%b f%b b%b want s0 f1 b0", o_stall, o_flush, o_bubble);
        end
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
            errors++; $display("FAIL jr_cnt: flush %0d stall %0d want 1 2", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_branch_override();
        do_reset();
        apply(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);          // lw $2
        apply(1, 2, 0, 1, 0, 5, 1, 0, 0, 1);          // consumer writing $5, beq taken in EX
        checks++;
        if (o_flush !== 1'b1 || o_bubble !== 1'b1 || o_stall !== 1'b0) begin
            errors++; $display("FAIL br_prio: f%b b%b s%b want f1 b1 s0", o_flush, o_bubble, o_stall);
        end
        apply(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);          // reader of $5 sees no producer
        checks++;
        if (fwd_a !== 2'b00 || o_stall !== 1'b0) begin
            errors++; $display("FAIL br_squash: fwd_a %b stall %b want 00 0", fwd_a, o_stall);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);      // j
            checks++;
            if (o_flush_s !== 1'b1) begin
                errors++; $display("FAIL sat_flush%0d: got %b want 1", i, o_flush_s);
            end
        end
        checks++;
        if (flush_cnt_s !== 2'd3 || flush_cnt !== 32'd5) begin
            errors++; $display("FAIL sat_cnt: narrow %0d wide %0d want 3 5", flush_cnt_s, flush_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);          // lw $2
        drive(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL ar_pre: stall %b want 1", stall);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b} !== 7'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL ar_clear: s%b f%b b%b fwd %b/%b cnt %0d/%0d want all 0",
                               stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
        checks++;
        if (o_stall !== 1'b0) begin
            errors++; $display("FAIL ar_after: stall %b want 0", o_stall);
        end
    endtask

    task automatic test_random();
        int rs, rt, dst, npc;
        bit v, urs, urt, rw, ld, br;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 9) != 0);
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            urs = $urandom_range(0, 1);
            urt = $urandom_range(0, 1);
            dst = $urandom_range(0, 3);
            rw  = $urandom_range(0, 3) != 0;
            ld  = rw && ($urandom_range(0, 2) == 0);
            npc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            br  = ($urandom_range(0, 11) == 0);
            if (npc == 3) begin urs = 1; rt = 0; end
            apply(v, rs, rt, urs, urt, dst, rw, ld, npc, br);
            checks++;
            if ({o_stall, o_flush, o_bubble} !== {e_stall, e_flush, e_bubble} ||
                {o_stall_s, o_flush_s, o_bubble_s} !== {e_stall, e_flush, e_bubble}) begin
                errors++; $display("FAIL rnd_ctl@%0d: got s%b f%b b%b want s%b f%b b%b",
                                   n, o_stall, o_flush, o_bubble, e_stall, e_flush, e_bubble);
            end
            checks++;
            if (fwd_a !== 2'(m_fwd_a) || fwd_b !== 2'(m_fwd_b) ||
                fwd_a_s !== 2'(m_fwd_a) || fwd_b_s !== 2'(m_fwd_b)) begin
                errors++; $display("FAIL rnd_fwd@%0d: got %b/%b want %0d/%0d", n, fwd_a, fwd_b, m_fwd_a, m_fwd_b);
            end
            checks++;
            if (stall_cnt !== 32'(m_scnt) || flush_cnt !== 32'(m_fcnt) ||
                stall_cnt_s !== 2'(m_scnt_s) || flush_cnt_s !== 2'(m_fcnt_s)) begin
                errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", n,
                                   stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s,
                                   m_scnt, m_fcnt, m_scnt_s, m_fcnt_s);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_ex_forward();
        test_zero_reg();
        test_jr();
        test_branch_override();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
